// File: rtl/game_event_timer.sv
`default_nettype none
// ============================================================================
//  Module      : game_event_timer
//  Description : Frame-based delay timer for game_control. Paces the post-hit
//                freeze, the respawn pause and the extra-life pause, emitting a
//                single-cycle `counter` pulse when each phase expires, and
//                blinks the character while it respawns.
//  Revision    : 1.0 - initial release
// ============================================================================
module game_event_timer #(
  parameter int HIT_FRAMES     = 60,
  parameter int RESPAWN_FRAMES = 90,
  parameter int LIFE_FRAMES    = 30,
  parameter int BLINK_FRAMES   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       charHit,
  input  logic       gotLife,
  input  logic       gameover,
  output logic       counter,
  output logic       busy,
  output logic [1:0] phase,
  output logic       blink
);

  // Phase encoding doubles as the externally visible `phase` value.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_FREEZE  = 2'b01;
  localparam logic [1:0] ST_RESPAWN = 2'b10;
  localparam logic [1:0] ST_LIFE    = 2'b11;

  localparam logic [7:0] C_HIT     = 8'(HIT_FRAMES);
  localparam logic [7:0] C_RESPAWN = 8'(RESPAWN_FRAMES);
  localparam logic [7:0] C_LIFE    = 8'(LIFE_FRAMES);
  localparam logic [7:0] C_BLINK   = 8'(BLINK_FRAMES);

  logic [1:0] state_q,   state_d;
  logic [7:0] cnt_q,     cnt_d;
  logic [7:0] bcnt_q,    bcnt_d;
  logic       counter_q, counter_d;
  logic       busy_q,    busy_d;
  logic       blink_q,   blink_d;

  // State and registered-output flops; reset dominates every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      bcnt_q    <= 8'd0;
      counter_q <= 1'b0;
      busy_q    <= 1'b0;
      blink_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      counter_q <= counter_d;
      busy_q    <= busy_d;
      blink_q   <= blink_d;
    end
  end

  // Next-state logic: triggers, frame countdown, expiry and abort handling.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    counter_d = 1'b0;
    blink_d   = blink_q;

    if (gameover) begin
      // Abort: no pulse, counters cleared, triggers ignored while held.
      state_d = ST_IDLE;
      cnt_d   = 8'd0;
      bcnt_d  = 8'd0;
      blink_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          blink_d = 1'b1;
          // A frame tick arriving with the trigger is deliberately not counted.
          if (charHit) begin
            state_d = ST_FREEZE;
            cnt_d   = C_HIT;
          end else if (gotLife) begin
            state_d = ST_LIFE;
            cnt_d   = C_LIFE;
          end
        end

        ST_FREEZE: begin
          // Hits and extra lives are ignored here: the character is invulnerable.
          blink_d = 1'b1;
          if (startOfFrame) begin
            if (cnt_q == 8'd1) begin
              counter_d = 1'b1;
              state_d   = ST_RESPAWN;
              cnt_d     = C_RESPAWN;
              bcnt_d    = C_BLINK;
              blink_d   = 1'b0;
            end else if (cnt_q != 8'd0) begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end

        ST_RESPAWN: begin
          if (startOfFrame) begin
            if (cnt_q == 8'd1) begin
              counter_d = 1'b1;
              state_d   = ST_IDLE;
              cnt_d     = 8'd0;
              bcnt_d    = 8'd0;
              blink_d   = 1'b1;
            end else begin
              if (cnt_q != 8'd0) begin
                cnt_d = cnt_q - 8'd1;
              end
              // Blink half-period runs off the same frame ticks.
              if (bcnt_q == 8'd1) begin
                blink_d = ~blink_q;
                bcnt_d  = C_BLINK;
              end else if (bcnt_q != 8'd0) begin
                bcnt_d = bcnt_q - 8'd1;
              end
            end
          end
        end

        ST_LIFE: begin
          blink_d = 1'b1;
          // Expiry wins over a coincident hit: the pulse goes out, the hit drops.
          if (startOfFrame && (cnt_q == 8'd1)) begin
            counter_d = 1'b1;
            state_d   = ST_IDLE;
            cnt_d     = 8'd0;
          end else if (charHit) begin
            state_d = ST_FREEZE;
            cnt_d   = C_HIT;
          end else if (startOfFrame && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          bcnt_d  = 8'd0;
          blink_d = 1'b1;
        end
      endcase
    end
  end

  // Output logic: busy tracks the upcoming phase so it registers alongside it.
  always_comb begin
    busy_d  = (state_d != ST_IDLE);
    counter = counter_q;
    busy    = busy_q;
    phase   = state_q;
    blink   = blink_q;
  end

endmodule
`default_nettype wire

// File: doc/game_event_timer.md
Name: game_event_timer

Overview:
- Frame-based delay timer that generates the single-cycle `counter` pulse consumed by game_control.
- Paces the post-hit pause, the respawn pause and the extra-life pause, and drives a character blink during respawn.
- Sits between the collision/bonus logic, the VGA frame-tick source and game_control; operates on game-control events only.

Parameters:
- HIT_FRAMES, 60, frames from charHit to the first counter pulse (freeze phase); legal range 1..255.
- RESPAWN_FRAMES, 90, frames from the first pulse to the second pulse (respawn phase); legal range 1..255.
- LIFE_FRAMES, 30, frames from gotLife to the counter pulse; legal range 1..255.
- BLINK_FRAMES, 6, frames per blink half-period during respawn; legal range 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame
- charHit  in  1  one-cycle character-hit event
- gotLife  in  1  one-cycle extra-life pickup event
- gameover  in  1  level signal from game_control; aborts the timer
- counter  out  1  one-cycle pulse when the current phase expires
- busy  out  1  high while any phase is active
- phase  out  2  00 IDLE, 01 FREEZE, 10 RESPAWN, 11 LIFE
- blink  out  1  character-visibility toggle; 1 = visible

Behaviour:
- Sync reset, active-high, wins over all inputs. Reset values: state IDLE, frame count 0, counter 0, busy 0, phase 00, blink 1, blink count 0.
- Internal registers: 8-bit frame count `cnt`, 8-bit blink count `bcnt`. All outputs are registered.
- IDLE:
  - charHit loads cnt=HIT_FRAMES and enters FREEZE.
  - Otherwise gotLife loads cnt=LIFE_FRAMES and enters LIFE.
  - charHit has priority when both arrive in the same cycle.
- FREEZE / RESPAWN / LIFE countdown:
  - Each startOfFrame decrements cnt.
  - A startOfFrame in the same cycle as the trigger is not counted.
  - On the startOfFrame that takes cnt from 1 to 0, counter is 1 in the next cycle (the registered output), exactly once.
  - Latency: counter rises 1 cycle after the Nth counted startOfFrame.
- FREEZE expiry: pulse counter, load cnt=RESPAWN_FRAMES, load bcnt=BLINK_FRAMES, set blink 0, and enter RESPAWN in the same cycle.
- RESPAWN:
  - Each startOfFrame decrements bcnt. At 1→0, blink toggles and bcnt reloads BLINK_FRAMES.
  - On expiry: pulse counter, set blink 1, enter IDLE.
- LIFE expiry: pulse counter, enter IDLE.
- Outside RESPAWN, blink is held at 1.
- Preemption and retriggering:
  - charHit during LIFE aborts LIFE with no pulse and restarts FREEZE with cnt=HIT_FRAMES.
  - gotLife during FREEZE, RESPAWN or LIFE is ignored.
  - charHit during FREEZE or RESPAWN is ignored (invulnerable window).
- Expiry collisions:
  - A trigger arriving in the same cycle as an expiry that returns to IDLE is ignored. Upstream must re-issue it.
  - charHit on the LIFE expiry cycle: the pulse is still issued and the hit is dropped.
- gameover=1:
  - Forces IDLE and clears cnt and bcnt in the next cycle, with no counter pulse; blink becomes 1.
  - While gameover stays high, triggers are ignored.
- busy = (phase != IDLE).
- counter is never high for 2 consecutive cycles.
- counter is never asserted in IDLE except on the expiry cycle itself.

Test Plan:
- Reset: assert reset for 3 cycles with charHit=1 → counter=0, busy=0, phase=00, blink=1 during and after.
- Hit sequence (HIT_FRAMES=3, RESPAWN_FRAMES=4, startOfFrame every 10 cycles): pulse charHit → phase=01. counter pulses 1 cycle after the 3rd frame tick, then phase=10. A second counter pulse follows 1 cycle after the 4th further tick, then phase=00.
- Blink (BLINK_FRAMES=2, RESPAWN_FRAMES=6): during RESPAWN, blink reads 0,0,1,1,0,0 across frames 1..6. blink=1 after exit.
- Life and preemption (LIFE_FRAMES=5): gotLife, then 2 ticks, then charHit → no counter pulse, phase=01 and cnt restarts at HIT_FRAMES. charHit and gotLife in the same cycle → phase=01.
- Abort: gameover=1 mid-RESPAWN → next cycle phase=00, blink=1, no counter pulse. charHit while gameover=1 → ignored.
- Edge ticks: startOfFrame coincident with the trigger is not counted (HIT_FRAMES=1 → pulse after the next tick, not the same one). gotLife during FREEZE → no change to cnt or to the pulse timing.
